// File: rtl/dh_pkg.sv
// ============================================================================
//  Module   : dh_pkg
//  Purpose  : Shared types and constants for the DH parameter loader.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package dh_pkg;

    localparam int          FRAME_BYTES = 16;
    localparam logic [31:0] P_MIN       = 32'd3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        CHECK     = 3'd2,
        START     = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

    // A usable group needs a modulus of at least P_MIN and a generator in [1, p-1].
    function automatic logic params_ok(input logic [31:0] gen, input logic [31:0] modulus);
        return (modulus >= P_MIN) && (gen != 32'd0) && (gen < modulus);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dh_shift128.sv
// ============================================================================
//  Module   : dh_shift128
//  Purpose  : 128-bit shadow register; bytes shift in at the LSB end.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dh_shift128
    import dh_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load_en,
    input  logic [7:0]   din,
    output logic [127:0] dout
);

    logic [127:0] r_data;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_data <= '0;
        end else if (load_en) begin
            r_data <= {r_data[119:0], din};
        end
    end

    assign dout = r_data;

endmodule

`default_nettype wire

// File: rtl/dh_param_loader.sv
// ============================================================================
//  Module   : dh_param_loader
//  Purpose  : Collects a 16-byte G/P/X/Y frame, validates it and starts the
//             key-exchange core.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dh_param_loader
    import dh_pkg::*;
#(
    parameter int TMO_CYC     = 255,
    parameter int FRAME_BYTES = dh_pkg::FRAME_BYTES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  din,
    input  logic        din_vld,
    output logic        din_rdy,
    input  logic        core_done,
    output logic [31:0] g,
    output logic [31:0] p,
    output logic [31:0] x,
    output logic [31:0] y,
    output logic        st,
    output logic        busy,
    output logic        err
);

    localparam int                  c_idle_w   = $clog2(TMO_CYC + 1);
    localparam logic [c_idle_w-1:0] c_idle_max = c_idle_w'(TMO_CYC - 1);
    localparam logic [c_idle_w-1:0] c_idle_one = c_idle_w'(1);
    localparam logic [4:0]          c_last_cnt = 5'(FRAME_BYTES - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [4:0]           r_cnt;
    logic [c_idle_w-1:0]  r_idle;
    logic                 r_err;
    logic [31:0]          r_g, r_p, r_x, r_y;
    logic [127:0]         w_shadow;
    logic                 w_accept;
    logic                 w_last_byte;
    logic                 w_timeout;
    logic                 w_params_ok;
    logic                 w_reject;

    assign din_rdy     = (r_state == IDLE) || (r_state == LOAD);
    assign w_accept    = din_vld && din_rdy;
    assign w_last_byte = w_accept && (r_state == LOAD) && (r_cnt == c_last_cnt);
    // The idle count holds the number of completed empty cycles; the edge that
    // would complete the TMO_CYC-th one aborts the frame instead.
    assign w_timeout   = (r_state == LOAD) && !w_accept && (r_idle == c_idle_max);
    assign w_params_ok = params_ok(w_shadow[127:96], w_shadow[95:64]);
    assign w_reject    = (r_state == CHECK) && !w_params_ok;

    dh_shift128 u_shadow (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_timeout || w_reject),
        .load_en (w_accept),
        .din     (din),
        .dout    (w_shadow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:      if (w_accept) w_state_nxt = LOAD;
            LOAD: begin
                if (w_last_byte) begin
                    w_state_nxt = CHECK;
                end else if (w_timeout) begin
                    w_state_nxt = IDLE;
                end
            end
            CHECK:     w_state_nxt = w_params_ok ? START : IDLE;
            START:     w_state_nxt = WAIT_DONE;
            WAIT_DONE: if (core_done) w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_idle <= '0;
            r_err  <= 1'b0;
            r_g    <= '0;
            r_p    <= '0;
            r_x    <= '0;
            r_y    <= '0;
        end else begin
            if (w_accept) begin
                r_cnt <= (r_state == IDLE) ? 5'd1 : r_cnt + 5'd1;
            end else if (!din_rdy || w_timeout) begin
                r_cnt <= '0;
            end

            if (w_accept || r_state != LOAD || w_timeout) begin
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + c_idle_one;
            end

            if ((r_state == IDLE) && w_accept) begin
                r_err <= 1'b0;
            end else if (w_timeout || w_reject) begin
                r_err <= 1'b1;
            end

            if ((r_state == CHECK) && w_params_ok) begin
                r_g <= w_shadow[127:96];
                r_p <= w_shadow[95:64];
                r_x <= w_shadow[63:32];
                r_y <= w_shadow[31:0];
            end
        end
    end

    assign g    = r_g;
    assign p    = r_p;
    assign x    = r_x;
    assign y    = r_y;
    assign err  = r_err;
    assign st   = (r_state == START);
    assign busy = (r_state == START) || (r_state == WAIT_DONE);

endmodule

`default_nettype wire

// File: tb/tb_dh_param_loader.sv
// ============================================================================
//  Module   : tb_dh_param_loader
//  Purpose  : Self-checking bench for dh_param_loader with a frame-level model.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dh_param_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  din = 8'h00;
    logic        din_vld = 1'b0;
    logic        din_rdy;
    logic        core_done = 1'b0;
    logic [31:0] g, p, x, y;
    logic        st, busy, err;

    int checks   = 0;
    int failures = 0;
    int st_seen  = 0;

    logic [31:0] exp_g = '0, exp_p = '0, exp_x = '0, exp_y = '0;
    logic        exp_err = 1'b0;

    dh_param_loader #(.TMO_CYC(255), .FRAME_BYTES(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_vld   (din_vld),
        .din_rdy   (din_rdy),
        .core_done (core_done),
        .g         (g),
        .p         (p),
        .x         (x),
        .y         (y),
        .st        (st),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (st === 1'b1) st_seen++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Frame acceptance rule from the parameter definition, independent of the DUT.
    function automatic bit model_valid(input logic [31:0] mg, input logic [31:0] mp);
        return (mp >= 32'd3) && (mg != 32'd0) && (mg < mp);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        din       = b;
        din_vld   = 1'b1;
        core_done = 1'b0;
        checks++;
        if (din_rdy !== 1'b1) begin
            failures++;
            $display("FAIL rdy_on_send got=%b exp=1", din_rdy);
        end
        tick();
        din_vld = 1'b0;
        din     = 8'($urandom);
    endtask

    task automatic idle_gap(input int n);
        for (int k = 0; k < n; k++) begin
            din       = 8'($urandom);
            core_done = 1'($urandom);
            tick();
        end
        core_done = 1'b0;
    endtask

    task automatic finish_core(input int delay);
        checks++;
        if (st !== 1'b0 || busy !== 1'b1 || din_rdy !== 1'b0) begin
            failures++;
            $display("FAIL wait_done_state st=%b busy=%b rdy=%b exp 0/1/0", st, busy, din_rdy);
        end
        idle_gap(0);
        for (int k = 0; k < delay; k++) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || din_rdy !== 1'b1) begin
            failures++;
            $display("FAIL after_done busy=%b rdy=%b exp 0/1", busy, din_rdy);
        end
    endtask

    // Sends one frame; returns at the cycle where ST is due (START or back in IDLE).
    task automatic run_frame(input logic [31:0] fg, input logic [31:0] fp,
                             input logic [31:0] fx, input logic [31:0] fy,
                             input int max_gap, input int long_at, input bit do_done);
        logic [127:0] fr;
        bit           ok;
        fr = {fg, fp, fx, fy};
        ok = model_valid(fg, fp);
        for (int i = 0; i < 16; i++) begin
            send_byte(fr[127-8*i -: 8]);
            if (i == 0) begin
                exp_err = 1'b0;
                checks++;
                if (err !== 1'b0) begin
                    failures++;
                    $display("FAIL err_clear_first got=%b exp=0", err);
                end
            end
            if (i < 15) begin
                if (i == long_at) tick_idle_254();
                else idle_gap($urandom_range(0, max_gap));
            end
        end
        checks++;
        if (st !== 1'b0 || din_rdy !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL check_cycle st=%b rdy=%b busy=%b exp 0/0/0", st, din_rdy, busy);
        end
        din_vld = 1'b1;
        tick();
        din_vld = 1'b0;
        if (ok) begin
            exp_g = fg; exp_p = fp; exp_x = fx; exp_y = fy;
        end else begin
            exp_err = 1'b1;
        end
        checks++;
        if (st !== ok) begin
            failures++;
            $display("FAIL st_pulse got=%b exp=%b", st, ok);
        end
        checks++;
        if ({g, p, x, y} !== {exp_g, exp_p, exp_x, exp_y}) begin
            failures++;
            $display("FAIL outputs got=%h/%h/%h/%h exp=%h/%h/%h/%h", g, p, x, y, exp_g, exp_p, exp_x, exp_y);
        end
        checks++;
        if (err !== exp_err || busy !== ok || din_rdy !== !ok) begin
            failures++;
            $display("FAIL flags err=%b busy=%b rdy=%b exp %b/%b/%b", err, busy, din_rdy, exp_err, ok, !ok);
        end
        if (ok && do_done) begin
            tick();
            finish_core($urandom_range(0, 5));
        end
    endtask

    task automatic tick_idle_254();
        idle_gap(254);
    endtask

    task automatic check_zero_outputs(input string name);
        checks++;
        if ({g, p, x, y} !== 128'd0 || st !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || din_rdy !== 1'b1) begin
            failures++;
            $display("FAIL %s g=%h p=%h x=%h y=%h st=%b busy=%b err=%b rdy=%b exp zeros rdy=1",
                     name, g, p, x, y, st, busy, err, din_rdy);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        din_vld = 1'b1;
        din = 8'($urandom);
        tick();
        tick();
        rst = 1'b0;
        din_vld = 1'b0;
        exp_g = '0; exp_p = '0; exp_x = '0; exp_y = '0; exp_err = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        check_zero_outputs("reset_state");
    endtask

    task automatic test_basic_vector();
        run_frame(32'd5, 32'd23, 32'd6, 32'd15, 0, -1, 1'b1);
    endtask

    task automatic test_invalid_frames();
        run_frame(32'd1, 32'd2, 32'h1234, 32'h5678, 2, -1, 1'b0);
        run_frame(32'h17, 32'h17, 32'd9, 32'd9, 1, -1, 1'b0);
        run_frame(32'd0, 32'd100, 32'd1, 32'd1, 1, -1, 1'b0);
        run_frame(32'd2, 32'd3, 32'd7, 32'd8, 1, -1, 1'b1);
    endtask

    task automatic test_timeout();
        logic [7:0] b;
        for (int i = 0; i < 7; i++) begin
            b = 8'($urandom);
            send_byte(b);
        end
        idle_gap(254);
        checks++;
        if (err !== 1'b0 || din_rdy !== 1'b1) begin
            failures++;
            $display("FAIL pre_timeout err=%b rdy=%b exp 0/1", err, din_rdy);
        end
        idle_gap(1);
        exp_err = 1'b1;
        checks++;
        if (err !== 1'b1 || din_rdy !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout err=%b rdy=%b busy=%b exp 1/1/0", err, din_rdy, busy);
        end
        run_frame(32'd7, 32'd101, 32'd33, 32'd44, 1, -1, 1'b1);
        run_frame(32'd9, 32'd97, 32'd12, 32'd13, 0, 4, 1'b1);
    endtask

    task automatic test_reset_midflight();
        int st0;
        for (int i = 0; i < 10; i++) send_byte(8'($urandom));
        apply_reset();
        check_zero_outputs("reset_midframe");
        st0 = st_seen;
        run_frame(32'd2, 32'd11, 32'd3, 32'd4, 1, -1, 1'b1);
        checks++;
        if (st_seen - st0 !== 1) begin
            failures++;
            $display("FAIL single_st got=%0d exp=1", st_seen - st0);
        end
        run_frame(32'd3, 32'd13, 32'd5, 32'd6, 0, -1, 1'b0);
        tick();
        apply_reset();
        check_zero_outputs("reset_wait_done");
    endtask

    task automatic test_wait_done_block();
        run_frame(32'd4, 32'd29, 32'd10, 32'd20, 0, -1, 1'b0);
        din_vld = 1'b1;
        for (int k = 0; k < 20; k++) begin
            din = 8'($urandom);
            tick();
            checks++;
            if (din_rdy !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL wait_block k=%0d rdy=%b busy=%b exp 0/1", k, din_rdy, busy);
            end
        end
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        din_vld   = 1'b0;
        checks++;
        if (busy !== 1'b0 || din_rdy !== 1'b1 || {g, p, x, y} !== {exp_g, exp_p, exp_x, exp_y}) begin
            failures++;
            $display("FAIL done_release busy=%b rdy=%b g=%h exp 0/1 g=%h", busy, din_rdy, g, exp_g);
        end
        run_frame(32'd6, 32'd31, 32'd1, 32'd2, 0, -1, 1'b1);
    endtask

    task automatic test_random();
        logic [31:0] rg, rp;
        for (int n = 0; n < 12; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                rg = $urandom_range(0, 6);
                rp = $urandom_range(0, 6);
            end else begin
                rg = $urandom;
                rp = $urandom;
            end
            run_frame(rg, rp, $urandom, $urandom, 3, -1, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_basic_vector();
        test_invalid_frames();
        test_timeout();
        test_reset_midflight();
        test_wait_done_block();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
